servant_mem_arbiter: RTL and testbench
======================================

Name: servant_mem_arbiter

Overview:
- Two-master Wishbone arbiter that shares the servant memory slave port between the SERV CPU (master 0) and the bootloader DMA engine (master 1).
- Sits between the CPU-side address decoder's memory port and the RAM.
- Serialises accesses, enforces bootloader-exclusive mode during image load, and recovers from a hung slave with a timeout acknowledge.

Parameters:
- PRIORITY, 0, 0 = round-robin between masters; 1 = fixed priority, master 0 (CPU) wins.
- TIMEOUT, 255, cycles of slave inactivity before forced ack; legal 2..65535.
- TW, 8, width of timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_boot_excl  in  1  1 = CPU requests masked (bootloader exclusive)
- i_m0_adr  in  32  CPU address
- i_m0_dat  in  32  CPU write data
- i_m0_sel  in  4  CPU byte select
- i_m0_we  in  1  CPU write enable
- i_m0_cyc  in  1  CPU cycle request
- o_m0_rdt  out  32  CPU read data
- o_m0_ack  out  1  CPU acknowledge
- i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc  in  32/32/4/1/1  bootloader master, same meaning as m0
- o_m1_rdt  out  32  bootloader read data
- o_m1_ack  out  1  bootloader acknowledge
- o_s_adr  out  32  memory address
- o_s_dat  out  32  memory write data
- o_s_sel  out  4  memory byte select
- o_s_we  out  1  memory write enable
- o_s_cyc  out  1  memory cycle
- i_s_rdt  in  32  memory read data
- i_s_ack  in  1  memory acknowledge
- o_grant  out  2  one-hot current owner; 00 = idle
- o_timeout  out  1  one-cycle pulse on forced ack

Behaviour:
- Reset: clock i_clk; reset i_rst, synchronous, active-high.
  - State IDLE, o_grant=00, last-owner=1 (CPU wins the first round-robin tie).
  - Timeout counter 0; all acks, o_s_cyc and o_timeout are 0.
  - Reset mid-transaction drops o_s_cyc next edge and gives no ack.
- States: IDLE, OWN0, OWN1.
- IDLE arbitration:
  - req0 = i_m0_cyc & !i_boot_excl; req1 = i_m1_cyc.
  - Only one request: go to its OWN state.
  - Both requests, PRIORITY=1: OWN0.
  - Both requests, PRIORITY=0: grant the master that did not own last.
  - No request: stay in IDLE.
  - Decision is registered, so first o_s_cyc appears one cycle after the request.
- OWNx datapath:
  - o_s_adr/dat/sel/we mux from master x.
  - o_s_cyc = i_mx_cyc.
  - o_mx_ack = i_s_ack, combinational; o_mx_rdt = i_s_rdt.
  - The non-owner sees ack=0 and rdt=0.
  - In IDLE, slave outputs are all 0.
- OWNx exit:
  - i_s_ack: go to IDLE and update last-owner=x.
  - i_mx_cyc deasserts before ack (abort): go to IDLE with no ack; last-owner is updated.
  - Timeout counter equals TIMEOUT-1 without ack:
    - Registered o_mx_ack=1 for exactly one cycle with o_mx_rdt=0, plus o_timeout pulse.
    - Then go to IDLE.
    - o_s_cyc is forced 0 during the forced-ack cycle.
- Timeout counter: cleared on entry to OWNx; increments each OWN cycle without ack; saturates.
- Minimum spacing: one IDLE cycle between consecutive grants, so a single master gets back-to-back accesses every 3 cycles with a 1-cycle-ack slave.
- i_boot_excl rising during OWN0 does not abort; it takes effect at the next IDLE.
- Simultaneous i_s_ack and timeout on the same cycle: the slave ack wins and o_timeout stays 0.
- o_grant reflects the state: OWN0=01, OWN1=10.

Decomposition:
- Package servant_arb_pkg:
  - state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - master index constants M_CPU=0, M_BOOT=1;
  - localparam for the idle bus value.
- Sub-module servant_wb_timeout: loadable saturating counter with clear, enable and expiry compare against TIMEOUT. It is reused by other bus bridges.

Test Plan:
- CPU-only read, adr=0x0000_0100, slave acks 1 cycle after cyc with rdt=0xDEADBEEF:
  - o_grant=01 at cycle 1 and o_s_cyc at cycle 1.
  - o_m0_ack at cycle 2 with rdt=0xDEADBEEF.
  - Back to IDLE at cycle 3.
- Both masters request continuously, PRIORITY=0: grants alternate 01,10,01,10 over 4 transactions. With PRIORITY=1, all 4 grants are 01.
- i_boot_excl=1, both cyc high, bootloader writes 0x1234_5678 with sel=0xF:
  - Only OWN1 grants; o_m0_ack stays 0.
  - Dropping excl lets the CPU get the next grant.
- Slave never acks, TIMEOUT=4:
  - o_m1_ack=1 and o_timeout=1 on the 4th OWN cycle, with o_m1_rdt=0.
  - o_s_cyc=0 on that cycle; IDLE follows.
- Master 0 drops cyc after 2 OWN cycles with no ack: IDLE next cycle, no ack pulses, and master 1 pending is granted next.
- i_rst asserted during OWN1 with cyc high: next edge gives o_grant=00, o_s_cyc=0 and no ack. After release, a pending CPU request is granted first.

Source files
------------

// File: rtl/servant_arb_pkg.sv
// Shared types and constants for the servant memory arbiter.
// State encoding doubles as the one-hot grant vector.
package servant_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic M_CPU  = 1'b0;
  localparam logic M_BOOT = 1'b1;

  localparam logic [31:0] IDLE_BUS = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
  } wb_req_t;

  // Owner index recorded when leaving an OWN state.
  function automatic logic owner_of(arb_state_e s);
    return (s == OWN1) ? M_BOOT : M_CPU;
  endfunction

endpackage

// File: rtl/servant_wb_timeout.sv
// Loadable saturating cycle counter with expiry compare.
// Shared by the bus bridges to detect a hung slave.
module servant_wb_timeout #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          ld_i,
  input  logic [TW-1:0] ld_val_i,
  output logic          expired_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Clear beats load beats count; count holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i && (cnt_q != {TW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/servant_mem_arbiter.sv
// Two-master Wishbone arbiter in front of the servant RAM.
// CPU is master 0, bootloader DMA is master 1.
module servant_mem_arbiter
  import servant_arb_pkg::*;
#(
  parameter int unsigned PRIORITY = 0,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TW       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_boot_excl,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m0_we,
  input  logic        i_m0_cyc,
  output logic [31:0] o_m0_rdt,
  output logic        o_m0_ack,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_we,
  input  logic        i_m1_cyc,
  output logic [31:0] o_m1_rdt,
  output logic        o_m1_ack,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  output logic [3:0]  o_s_sel,
  output logic        o_s_we,
  output logic        o_s_cyc,
  input  logic [31:0] i_s_rdt,
  input  logic        i_s_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_q;
  logic       last_d;

  wb_req_t    m0;
  wb_req_t    m1;
  wb_req_t    own;

  logic       req0;
  logic       req1;
  logic       owning;
  logic       expired;
  logic       forced;
  logic       ack_own;
  logic [31:0] rdt_own;

  assign m0 = '{adr: i_m0_adr, dat: i_m0_dat,
                sel: i_m0_sel, we: i_m0_we,
                cyc: i_m0_cyc};
  assign m1 = '{adr: i_m1_adr, dat: i_m1_dat,
                sel: i_m1_sel, we: i_m1_we,
                cyc: i_m1_cyc};

  assign req0   = i_m0_cyc & ~i_boot_excl;
  assign req1   = i_m1_cyc;
  assign owning = (state_q != IDLE);
  assign own    = (state_q == OWN1) ? m1 : m0;

  // A forced ack only when the slave stays silent on the
  // expiry cycle and the owner is still in its cycle.
  assign forced  = owning & expired & own.cyc & ~i_s_ack;
  assign ack_own = i_s_ack | forced;
  assign rdt_own = forced ? IDLE_BUS : i_s_rdt;

  // Counts OWN cycles without a slave ack; cleared while idle
  // so every grant starts from zero.
  servant_wb_timeout #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timeout (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .clr_i     (~owning),
    .en_i      (owning & ~i_s_ack),
    .ld_i      (1'b0),
    .ld_val_i  ({TW{1'b0}}),
    .expired_o (expired)
  );

  // State and last-owner registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= M_BOOT;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Arbitration in IDLE; ack, abort or expiry ends ownership.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          if ((PRIORITY != 0) || (last_q == M_BOOT)) begin
            state_d = OWN0;
          end else begin
            state_d = OWN1;
          end
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (i_s_ack || !own.cyc || expired) begin
          state_d = IDLE;
          last_d  = owner_of(state_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slave mux from the owner, acks routed back to it only.
  always_comb begin
    o_s_adr   = IDLE_BUS;
    o_s_dat   = IDLE_BUS;
    o_s_sel   = 4'h0;
    o_s_we    = 1'b0;
    o_s_cyc   = 1'b0;
    o_m0_ack  = 1'b0;
    o_m0_rdt  = IDLE_BUS;
    o_m1_ack  = 1'b0;
    o_m1_rdt  = IDLE_BUS;
    o_timeout = 1'b0;
    o_grant   = state_q;
    if (owning) begin
      o_s_adr   = own.adr;
      o_s_dat   = own.dat;
      o_s_sel   = own.sel;
      o_s_we    = own.we;
      o_s_cyc   = own.cyc & ~expired;
      o_timeout = forced;
    end
    unique case (state_q)
      OWN0: begin
        o_m0_ack = ack_own;
        o_m0_rdt = rdt_own;
      end
      OWN1: begin
        o_m1_ack = ack_own;
        o_m1_rdt = rdt_own;
      end
      default: begin
        o_grant = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_servant_mem_arbiter.sv
// Bench for servant_mem_arbiter: table vectors, directed
// corner sequences and a randomized run against a model.
module tb_servant_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        excl = 1'b0;
  logic [31:0] m0_adr = '0, m0_dat = '0;
  logic [3:0]  m0_sel = '0;
  logic        m0_we = 1'b0, m0_cyc = 1'b0;
  logic [31:0] m1_adr = '0, m1_dat = '0;
  logic [3:0]  m1_sel = '0;
  logic        m1_we = 1'b0, m1_cyc = 1'b0;
  logic [31:0] s_rdt = 32'hDEADBEEF;
  logic        ack_drv = 1'b0;
  logic        auto_slv = 1'b1;
  int          lat = 1;

  logic [31:0] m0_rdt, m1_rdt, s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        m0_ack, m1_ack, s_we, s_cyc, tmo, s_ack;
  logic [1:0]  grant;

  logic [31:0] p_m0_rdt, p_m1_rdt, p_s_adr, p_s_dat;
  logic [3:0]  p_s_sel;
  logic        p_m0_ack, p_m1_ack, p_s_we, p_s_cyc;
  logic        p_tmo, p_s_ack;
  logic [1:0]  p_grant;

  int age = 0, page = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // Slave model: acks after lat cycles of continuous cyc.
  always @(posedge clk) begin
    age  <= (rst || !s_cyc || s_ack) ? 0 : age + 1;
    page <= (rst || !p_s_cyc || p_s_ack) ? 0 : page + 1;
  end

  assign s_ack = auto_slv ? (s_cyc && age >= lat) : ack_drv;
  assign p_s_ack = auto_slv ? (p_s_cyc && page >= lat)
                            : ack_drv;

  servant_mem_arbiter #(.PRIORITY(0), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_boot_excl(excl),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat),
    .i_m0_sel(m0_sel), .i_m0_we(m0_we),
    .i_m0_cyc(m0_cyc), .o_m0_rdt(m0_rdt),
    .o_m0_ack(m0_ack),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat),
    .i_m1_sel(m1_sel), .i_m1_we(m1_we),
    .i_m1_cyc(m1_cyc), .o_m1_rdt(m1_rdt),
    .o_m1_ack(m1_ack),
    .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel),
    .o_s_we(s_we), .o_s_cyc(s_cyc),
    .i_s_rdt(s_rdt), .i_s_ack(s_ack),
    .o_grant(grant), .o_timeout(tmo)
  );

  servant_mem_arbiter #(.PRIORITY(1), .TIMEOUT(TO)) dutp (
    .i_clk(clk), .i_rst(rst), .i_boot_excl(excl),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat),
    .i_m0_sel(m0_sel), .i_m0_we(m0_we),
    .i_m0_cyc(m0_cyc), .o_m0_rdt(p_m0_rdt),
    .o_m0_ack(p_m0_ack),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat),
    .i_m1_sel(m1_sel), .i_m1_we(m1_we),
    .i_m1_cyc(m1_cyc), .o_m1_rdt(p_m1_rdt),
    .o_m1_ack(p_m1_ack),
    .o_s_adr(p_s_adr), .o_s_dat(p_s_dat),
    .o_s_sel(p_s_sel), .o_s_we(p_s_we),
    .o_s_cyc(p_s_cyc),
    .i_s_rdt(s_rdt), .i_s_ack(p_s_ack),
    .o_grant(p_grant), .o_timeout(p_tmo)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    excl = 1'b0;
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    m0_we = 1'b0; m1_we = 1'b0;
    ack_drv = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       excl;
    logic       c0;
    logic       c1;
    logic [1:0] g_rr;
    logic [1:0] g_pri;
  } vec_t;

  vec_t tbl[9];

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] g_rr[4];
    logic [1:0] g_pr[4];
    int         t_pr[4];
    int         nr, np, acks, wt;
    logic [1:0] prr, ppr;
    int         owner, n, last;
    logic       cx, fx, r0, r1;
    logic [1:0] eg;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 2'b01, 2'b01};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 2'b10, 2'b01};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 2'b01, 2'b01};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b10};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b01};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 2'b10, 2'b10};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 2'b01, 2'b01};

    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_tmo", tmo, 1'b0);
    chk("rst_s_adr", s_adr, 32'h0);
    chk("rst_p_grant", p_grant, 2'b00);

    // Arbitration table: grant, then abort back to IDLE
    for (int i = 0; i < 9; i++) begin
      excl = tbl[i].excl;
      m0_cyc = tbl[i].c0;
      m1_cyc = tbl[i].c1;
      tick();
      chk($sformatf("tbl%0d_rr", i), grant, tbl[i].g_rr);
      chk($sformatf("tbl%0d_pri", i), p_grant, tbl[i].g_pri);
      m0_cyc = 1'b0;
      m1_cyc = 1'b0;
      tick();
    end

    // CPU-only read, 1-cycle slave
    do_reset();
    auto_slv = 1'b1; lat = 1;
    s_rdt = 32'hDEADBEEF;
    m0_adr = 32'h0000_0100;
    m0_cyc = 1'b1;
    tick();
    chk("rd_c1_grant", grant, 2'b01);
    chk("rd_c1_s_cyc", s_cyc, 1'b1);
    chk("rd_c1_s_adr", s_adr, 32'h0000_0100);
    chk("rd_c1_ack", m0_ack, 1'b0);
    tick();
    chk("rd_c2_ack", m0_ack, 1'b1);
    chk("rd_c2_rdt", m0_rdt, 32'hDEADBEEF);
    chk("rd_c2_m1_rdt", m1_rdt, 32'h0);
    tick();
    chk("rd_c3_grant", grant, 2'b00);
    m0_cyc = 1'b0;

    // Both masters continuously requesting
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    nr = 0; np = 0; prr = 2'b00; ppr = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (grant != 2'b00 && prr == 2'b00 && nr < 4) begin
        g_rr[nr] = grant;
        nr++;
      end
      if (p_grant != 2'b00 && ppr == 2'b00 && np < 4) begin
        g_pr[np] = p_grant;
        t_pr[np] = c;
        np++;
      end
      prr = grant;
      ppr = p_grant;
    end
    chk("rr_count", nr, 4);
    chk("pri_count", np, 4);
    for (int k = 0; k < nr; k++)
      chk($sformatf("rr_grant%0d", k), g_rr[k],
          (k % 2 == 0) ? 2'b01 : 2'b10);
    for (int k = 0; k < np; k++) begin
      chk($sformatf("pri_grant%0d", k), g_pr[k], 2'b01);
      chk($sformatf("pri_cycle%0d", k), t_pr[k], 1 + 3 * k);
    end

    // Bootloader-exclusive write
    do_reset();
    excl = 1'b1;
    m0_cyc = 1'b1; m0_dat = 32'hCAFE_0000;
    m1_cyc = 1'b1; m1_we = 1'b1; m1_sel = 4'hF;
    m1_adr = 32'h0000_0200; m1_dat = 32'h1234_5678;
    acks = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("excl_no_cpu%0d", c), grant == 2'b01, 1'b0);
      chk($sformatf("excl_m0_ack%0d", c), m0_ack, 1'b0);
      if (grant == 2'b10) begin
        chk("excl_s_dat", s_dat, 32'h1234_5678);
        chk("excl_s_sel", s_sel, 4'hF);
        chk("excl_s_we", s_we, 1'b1);
      end
      if (m1_ack) acks++;
    end
    chk("excl_m1_acks", acks, 3);
    excl = 1'b0;
    wt = 0;
    while (grant == 2'b00 && wt < 6) begin
      tick();
      wt++;
    end
    chk("excl_release_grant", grant, 2'b01);
    m0_cyc = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0;

    // Hung slave: forced ack on 4th OWN cycle
    do_reset();
    auto_slv = 1'b1; lat = 1000;
    m1_cyc = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("to_c%0d_ack", c), m1_ack, 1'b0);
      chk($sformatf("to_c%0d_s_cyc", c), s_cyc, 1'b1);
      chk($sformatf("to_c%0d_tmo", c), tmo, 1'b0);
    end
    tick();
    chk("to_c4_ack", m1_ack, 1'b1);
    chk("to_c4_tmo", tmo, 1'b1);
    chk("to_c4_rdt", m1_rdt, 32'h0);
    chk("to_c4_s_cyc", s_cyc, 1'b0);
    tick();
    chk("to_c5_grant", grant, 2'b00);
    chk("to_c5_tmo", tmo, 1'b0);
    m1_cyc = 1'b0;

    // Slave ack on the expiry cycle wins
    do_reset();
    auto_slv = 1'b0; lat = 1;
    m1_cyc = 1'b1;
    tick(); tick(); tick();
    @(posedge clk);
    #1 ack_drv = 1'b1;
    @(negedge clk);
    chk("race_ack", m1_ack, 1'b1);
    chk("race_rdt", m1_rdt, 32'hDEADBEEF);
    chk("race_tmo", tmo, 1'b0);
    ack_drv = 1'b0;
    m1_cyc = 1'b0;
    tick();
    chk("race_idle", grant, 2'b00);

    // CPU aborts after 2 OWN cycles; boot pending
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    chk("ab_c1_grant", grant, 2'b01);
    tick();
    chk("ab_c2_ack", m0_ack, 1'b0);
    m0_cyc = 1'b0;
    tick();
    chk("ab_c3_grant", grant, 2'b00);
    chk("ab_c3_acks", {m0_ack, m1_ack}, 2'b00);
    tick();
    chk("ab_c4_grant", grant, 2'b10);
    m1_cyc = 1'b0;

    // Reset in the middle of OWN1
    do_reset();
    m1_cyc = 1'b1;
    tick();
    chk("mr_own1", grant, 2'b10);
    rst = 1'b1;
    m0_cyc = 1'b1;
    tick();
    chk("mr_grant", grant, 2'b00);
    chk("mr_s_cyc", s_cyc, 1'b0);
    chk("mr_ack", m1_ack, 1'b0);
    rst = 1'b0;
    tick();
    chk("mr_cpu_first", grant, 2'b01);

    // Randomized run against a transaction-level model
    do_reset();
    auto_slv = 1'b0;
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    owner = -1; n = 0; last = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 4) == 0) m1_cyc = ~m1_cyc;
      if ($urandom_range(0, 9) == 0) excl = ~excl;
      ack_drv = ($urandom_range(0, 3) == 0);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_we = $urandom_range(0, 1);
      m1_we = $urandom_range(0, 1);
      s_rdt = $urandom;
      #1;
      cx = (owner == 1) ? m1_cyc : m0_cyc;
      fx = (owner >= 0) && (n == TO) && cx && !ack_drv;
      eg = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
      chk("rnd_grant", grant, eg);
      chk("rnd_s_cyc", s_cyc, (owner >= 0) && cx && (n != TO));
      chk("rnd_s_adr", s_adr, (owner < 0) ? 32'h0 :
          ((owner == 0) ? m0_adr : m1_adr));
      chk("rnd_m0_ack", m0_ack, (owner == 0) && (ack_drv || fx));
      chk("rnd_m1_ack", m1_ack, (owner == 1) && (ack_drv || fx));
      chk("rnd_tmo", tmo, fx);
      chk("rnd_m0_rdt", m0_rdt,
          (owner == 0 && !fx) ? s_rdt : 32'h0);
      chk("rnd_m1_rdt", m1_rdt,
          (owner == 1 && !fx) ? s_rdt : 32'h0);
      @(posedge clk);
      if (owner < 0) begin
        r0 = m0_cyc && !excl;
        r1 = m1_cyc;
        if (r0 && r1) owner = (last == 1) ? 0 : 1;
        else if (r0) owner = 0;
        else if (r1) owner = 1;
        n = 1;
      end else if (ack_drv || !cx || n == TO) begin
        last = owner;
        owner = -1;
      end else begin
        n++;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
